// File: rtl/set_field_ctrl.sv
// Time-setting sequencer for the clock display.
// Steps the active field HOUR -> MIN -> SEC, drives the blink enables, issues
// increment pulses and leaves set mode on key_set or after an idle timeout.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   IDLE     | normal display, only key_set is honoured
//   SET_HOUR | hour field active, blink_en = 001
//   SET_MIN  | minute field active, blink_en = 010
//   SET_SEC  | second field active, blink_en = 100
module set_field_ctrl #(
    parameter int TICK_MAX  = 49_999_999,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_set,
    input  logic       key_next,
    input  logic       key_inc,
    output logic       set_mode,
    output logic [2:0] blink_en,
    output logic [2:0] inc_pulse,
    output logic       exit_pulse,
    output logic       exit_timeout
);

    localparam int TW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int SW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);
    localparam logic [SW-1:0] SEC_LAST  = SW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tick_cnt, tick_nx;
    logic [SW-1:0]   sec_cnt, sec_nx;
    logic [2:0]      inc_nx;
    logic            exit_nx, timeout_nx;
    logic            timeout_hit;

    assign timeout_hit = (tick_cnt == TICK_LAST) && (sec_cnt == SEC_LAST);

    // State, idle-timer and pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            sec_cnt      <= '0;
            inc_pulse    <= 3'b000;
            exit_pulse   <= 1'b0;
            exit_timeout <= 1'b0;
        end else begin
            state        <= state_nx;
            tick_cnt     <= tick_nx;
            sec_cnt      <= sec_nx;
            inc_pulse    <= inc_nx;
            exit_pulse   <= exit_nx;
            exit_timeout <= timeout_nx;
        end
    end

    // Next state, counter update and pulse requests; key_set > key_next > key_inc > timeout
    always_comb begin
        state_nx   = state;
        tick_nx    = '0;
        sec_nx     = '0;
        inc_nx     = 3'b000;
        exit_nx    = 1'b0;
        timeout_nx = 1'b0;
        if (state == IDLE) begin
            if (key_set) state_nx = SET_HOUR;
        end else if (key_set) begin
            state_nx = IDLE;
            exit_nx  = 1'b1;
        end else if (key_next) begin
            case (state)
                SET_HOUR: state_nx = SET_MIN;
                SET_MIN:  state_nx = SET_SEC;
                default:  state_nx = SET_HOUR;
            endcase
        end else if (key_inc) begin
            case (state)
                SET_HOUR: inc_nx = 3'b001;
                SET_MIN:  inc_nx = 3'b010;
                default:  inc_nx = 3'b100;
            endcase
        end else if (timeout_hit) begin
            state_nx   = IDLE;
            exit_nx    = 1'b1;
            timeout_nx = 1'b1;
        end else if (tick_cnt == TICK_LAST) begin
            sec_nx = sec_cnt + 1'b1;
        end else begin
            tick_nx = tick_cnt + 1'b1;
            sec_nx  = sec_cnt;
        end
    end

    // Field decode of the registered state
    always_comb begin
        case (state)
            SET_HOUR: blink_en = 3'b001;
            SET_MIN:  blink_en = 3'b010;
            SET_SEC:  blink_en = 3'b100;
            default:  blink_en = 3'b000;
        endcase
        set_mode = |blink_en;
    end

endmodule

// File: tb/tb_set_field_ctrl.sv
// Testbench for set_field_ctrl: directed scenarios plus bursty random keys,
// checked cycle by cycle against a queue of expected outputs.
module tb_set_field_ctrl;

    localparam int TICK_MAX  = 9;
    localparam int TIMEOUT_S = 3;
    localparam int TO_EDGES  = TIMEOUT_S * (TICK_MAX + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_set = 1'b0, key_next = 1'b0, key_inc = 1'b0;
    logic       set_mode, exit_pulse, exit_timeout;
    logic [2:0] blink_en, inc_pulse;

    typedef struct {
        logic       mode;
        logic [2:0] blink;
        logic [2:0] inc;
        logic       ex;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: field index 0 = not setting, 1..3 = hour/min/sec
    int   m_field = 0;
    int   m_idle  = 0;

    set_field_ctrl #(.TICK_MAX(TICK_MAX), .TIMEOUT_S(TIMEOUT_S)) dut (
        .clk(clk), .rst(rst),
        .key_set(key_set), .key_next(key_next), .key_inc(key_inc),
        .set_mode(set_mode), .blink_en(blink_en), .inc_pulse(inc_pulse),
        .exit_pulse(exit_pulse), .exit_timeout(exit_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every registered output set against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("set_mode", {2'b00, set_mode}, {2'b00, e.mode});
                chk("blink_en", blink_en, e.blink);
                chk("inc_pulse", inc_pulse, e.inc);
                chk("exit_pulse", {2'b00, exit_pulse}, {2'b00, e.ex});
                chk("exit_timeout", {2'b00, exit_timeout}, {2'b00, e.to});
            end
        end
    end

    // One clock edge with the given keys; the model predicts the outputs after it
    task automatic cycle(input logic s, input logic n, input logic i);
        exp_t e;
        @(negedge clk);
        key_set = s; key_next = n; key_inc = i;
        e.inc = 3'b000; e.ex = 1'b0; e.to = 1'b0;
        if (m_field == 0) begin
            if (s) m_field = 1;
            m_idle = 0;
        end else if (s) begin
            m_field = 0;
            e.ex = 1'b1;
            m_idle = 0;
        end else if (n) begin
            m_field = (m_field % 3) + 1;
            m_idle = 0;
        end else if (i) begin
            e.inc = 3'(1 << (m_field - 1));
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TO_EDGES) begin
                m_field = 0;
                m_idle = 0;
                e.ex = 1'b1;
                e.to = 1'b1;
            end
        end
        e.blink = (m_field == 0) ? 3'b000 : 3'(1 << (m_field - 1));
        e.mode  = (m_field != 0);
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic quiet(input int cycles);
        for (int k = 0; k < cycles; k++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset set_mode", {2'b00, set_mode}, 3'b000);
        chk("reset blink_en", blink_en, 3'b000);
        chk("reset inc_pulse", inc_pulse, 3'b000);
        chk("reset exit_pulse", {2'b00, exit_pulse}, 3'b000);
        chk("reset exit_timeout", {2'b00, exit_timeout}, 3'b000);
        @(negedge clk);
        rst = 1'b1;

        // Async reset in SET_MIN, then key_next alone stays IDLE
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        #3;
        rst = 1'b0;
        m_field = 0; m_idle = 0;
        #1;
        chk("async rst set_mode", {2'b00, set_mode}, 3'b000);
        chk("async rst blink_en", blink_en, 3'b000);
        chk("async rst inc_pulse", inc_pulse, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 1, 0);
        cycle(0, 0, 1);

        // Field walk with wrap
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        // Increment in SET_MIN, one cycle only
        cycle(0, 1, 0);
        cycle(0, 0, 1);
        quiet(2);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        // Manual exit from SET_SEC, then key_inc in IDLE
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        quiet(1);
        cycle(0, 0, 1);
        quiet(1);

        // Timeout after exactly TO_EDGES edges from entry
        cycle(1, 0, 0);
        quiet(TO_EDGES + 2);
        // key_inc at edge TO_EDGES-1 restarts the timeout
        cycle(1, 0, 0);
        quiet(TO_EDGES - 2);
        cycle(0, 0, 1);
        quiet(TO_EDGES + 2);
        // Keys coincident with the timeout edge win
        cycle(1, 0, 0);
        quiet(TO_EDGES - 1);
        cycle(0, 1, 0);
        quiet(TO_EDGES - 1);
        cycle(1, 0, 0);
        quiet(2);

        // Priority
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(1, 0, 0);

        // Bursty random keys, gaps long enough to reach timeouts
        for (int b = 0; b < 250; b++) begin
            int r;
            quiet($urandom_range(0, 36));
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    cycle(1, 0, 0);
                2, 3:    cycle(0, 1, 0);
                4, 5, 6: cycle(0, 0, 1);
                7:       cycle(1, 1, 1);
                8:       cycle(0, 1, 1);
                default: cycle(1, 0, 1);
            endcase
        end

        quiet(2);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
